// File: rtl/axi_lite_read_arbiter.sv
// Round-robin arbiter sharing one AXI4-Lite read port (AR + R) among NUM_REQ requesters.
// One outstanding read at a time. A watchdog on the data phase returns SLVERR and then
// drains the late beat before the next grant.
module axi_lite_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                        ACLK,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [1:0]                  rsp_resp,
  output logic                        M_ARVALID,
  output logic [ADDR_W-1:0]           M_ARADDR,
  output logic [2:0]                  M_ARPROT,
  input  logic                        M_ARREADY,
  input  logic                        M_RVALID,
  input  logic [DATA_W-1:0]           M_RDATA,
  input  logic [1:0]                  M_RRESP,
  output logic                        M_RREADY,
  output logic                        busy,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

  localparam int ID_W  = $clog2(NUM_REQ);
  // Wide enough to hold TIMEOUT-1; minimum one bit when the watchdog is disabled.
  localparam int CNT_W = $clog2(TIMEOUT + 2);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StData,
    StResp,
    StDrain
  } state_e;

  state_e              r_state;
  logic [ID_W-1:0]     r_grant_id;
  logic [ADDR_W-1:0]   r_araddr;
  logic [DATA_W-1:0]   r_rsp_data;
  logic [1:0]          r_rsp_resp;
  logic [NUM_REQ-1:0]  r_rsp_valid;
  logic                r_arvalid;
  logic                r_rready;
  logic                r_busy;
  logic                r_drain;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_any;
  logic [ID_W-1:0]     w_winner;
  logic                w_expire;

  // Round-robin scan starting just after the last grant; lowest offset wins.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(r_grant_id) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        w_any    = 1'b1;
        w_winner = ID_W'(idx);
      end
    end
  end

  // Accept pulse must coincide with the request, so it is decoded combinationally in idle.
  always_comb begin
    req_ready = '0;
    if (r_state == StIdle && w_any) begin
      req_ready = NUM_REQ'(1) << w_winner;
    end
  end

  // Watchdog expiry on the last allowed data cycle; a beat in that same cycle still wins.
  always_comb begin
    w_expire = 1'b0;
    if (TIMEOUT != 0) begin
      w_expire = (r_cnt == CNT_W'(TIMEOUT - 1));
    end
  end

  // Transaction sequencer with registered outputs.
  always_ff @(posedge ACLK or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_grant_id  <= ID_W'(NUM_REQ - 1);
      r_araddr    <= '0;
      r_rsp_data  <= '0;
      r_rsp_resp  <= 2'b00;
      r_rsp_valid <= '0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_busy      <= 1'b0;
      r_drain     <= 1'b0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_any) begin
            r_araddr   <= req_addr[int'(w_winner)*ADDR_W +: ADDR_W];
            r_grant_id <= w_winner;
            r_arvalid  <= 1'b1;
            r_busy     <= 1'b1;
            r_state    <= StAddr;
          end
        end
        StAddr: begin
          if (M_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_cnt     <= '0;
            r_state   <= StData;
          end
        end
        StData: begin
          r_cnt <= r_cnt + 1'b1;
          if (M_RVALID) begin
            r_rsp_data  <= M_RDATA;
            r_rsp_resp  <= M_RRESP;
            r_drain     <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= NUM_REQ'(1) << r_grant_id;
            r_state     <= StResp;
          end else if (w_expire) begin
            r_rsp_data  <= '0;
            r_rsp_resp  <= 2'b10;
            r_drain     <= 1'b1;
            r_rready    <= 1'b0;
            r_rsp_valid <= NUM_REQ'(1) << r_grant_id;
            r_state     <= StResp;
          end
        end
        StResp: begin
          r_rsp_valid <= '0;
          if (r_drain) begin
            r_rready <= 1'b1;
            r_state  <= StDrain;
          end else begin
            r_busy  <= 1'b0;
            r_state <= StIdle;
          end
        end
        StDrain: begin
          // Late beat is consumed here and never forwarded.
          if (M_RVALID) begin
            r_rready <= 1'b0;
            r_drain  <= 1'b0;
            r_busy   <= 1'b0;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_resp  = r_rsp_resp;
  assign M_ARVALID = r_arvalid;
  assign M_ARADDR  = r_araddr;
  assign M_ARPROT  = 3'b000;
  assign M_RREADY  = r_rready;
  assign busy      = r_busy;
  assign grant_id  = r_grant_id;

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// Directed bench for axi_lite_read_arbiter: 4 requesters, 8-cycle watchdog.
module tb_axi_lite_read_arbiter;

  logic        ACLK;
  logic        rst;
  logic [3:0]  req_valid;
  logic [127:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic        M_ARVALID;
  logic [31:0] M_ARADDR;
  logic [2:0]  M_ARPROT;
  logic        M_ARREADY;
  logic        M_RVALID;
  logic [31:0] M_RDATA;
  logic [1:0]  M_RRESP;
  logic        M_RREADY;
  logic        busy;
  logic [1:0]  grant_id;

  logic [31:0] addrs [4];
  int n_checks;
  int n_errors;

  axi_lite_read_arbiter #(
    .NUM_REQ(4),
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(8)
  ) dut (
    .ACLK     (ACLK),
    .rst      (rst),
    .req_valid(req_valid),
    .req_addr (req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_data (rsp_data),
    .rsp_resp (rsp_resp),
    .M_ARVALID(M_ARVALID),
    .M_ARADDR (M_ARADDR),
    .M_ARPROT (M_ARPROT),
    .M_ARREADY(M_ARREADY),
    .M_RVALID (M_RVALID),
    .M_RDATA  (M_RDATA),
    .M_RRESP  (M_RRESP),
    .M_RREADY (M_RREADY),
    .busy     (busy),
    .grant_id (grant_id)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  always_comb begin
    for (int i = 0; i < 4; i++) req_addr[i*32 +: 32] = addrs[i];
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_arvalid"}, M_ARVALID, 0);
    chk({tag, "_rready"}, M_RREADY, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_arprot"}, M_ARPROT, 0);
  endtask

  // Full read for requester id; caller has set req_valid and is 1 time unit past a posedge in idle.
  task automatic rd(input int id, input int ar_wait, input int r_wait,
                    input logic [31:0] data, input logic [1:0] resp);
    logic [3:0] onehot;
    onehot = 4'b0001 << id;
    #1;
    chk("req_ready", req_ready, onehot);
    chk("idle_busy", busy, 0);
    step();
    for (int i = 0; i <= ar_wait; i++) begin
      M_ARREADY = (i == ar_wait);
      #1;
      chk("arvalid", M_ARVALID, 1);
      chk("araddr", M_ARADDR, addrs[id]);
      chk("addr_req_ready", req_ready, 0);
      step();
    end
    M_ARREADY = 1'b0;
    for (int i = 0; i <= r_wait; i++) begin
      M_RVALID = (i == r_wait);
      M_RDATA  = data;
      M_RRESP  = resp;
      #1;
      chk("rready", M_RREADY, 1);
      chk("data_arvalid", M_ARVALID, 0);
      chk("data_rsp_valid", rsp_valid, 0);
      step();
    end
    M_RVALID = 1'b0;
    #1;
    chk("rsp_valid", rsp_valid, onehot);
    chk("rsp_data", rsp_data, data);
    chk("rsp_resp", rsp_resp, resp);
    chk("grant_id", grant_id, id);
    step();
    #1;
    chk("after_rsp_valid", rsp_valid, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_grant_id", grant_id, 3);
    chk("rst_araddr", M_ARADDR, 0);
    chk("rst_rsp_data", rsp_data, 0);
    check_idle_outputs("rst");
    step();
    rst = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    addrs[0]  = 32'h0000_0010;
    addrs[1]  = 32'h0000_0024;
    addrs[2]  = 32'h0000_0038;
    addrs[3]  = 32'h0000_004C;
    rst       = 1'b1;
    req_valid = 4'b0000;
    M_ARREADY = 1'b0;
    M_RVALID  = 1'b0;
    M_RDATA   = '0;
    M_RRESP   = 2'b00;
    step();
    do_reset();

    // 1: single request, zero-wait slave
    req_valid = 4'b0001;
    rd(0, 0, 0, 32'hCAFE_0001, 2'b00);
    req_valid = 4'b0000;

    // 2: all requesting after reset -> 0,1,2,3,0
    do_reset();
    req_valid = 4'b1111;
    rd(0, 0, 0, 32'hA000_0000, 2'b00);
    rd(1, 0, 1, 32'hA000_0001, 2'b00);
    rd(2, 0, 0, 32'hA000_0002, 2'b00);
    rd(3, 0, 2, 32'hA000_0003, 2'b00);
    rd(0, 0, 0, 32'hA000_0004, 2'b00);

    // 3: ARREADY low for 10 cycles, longer than the data watchdog
    req_valid = 4'b0100;
    rd(2, 10, 0, 32'h5555_AAAA, 2'b00);

    // 5: error response forwarded
    req_valid = 4'b1000;
    rd(3, 0, 3, 32'hDEAD_BEEF, 2'b11);

    // 4: watchdog expiry, then drain of the late beat
    req_valid = 4'b0010;
    #1;
    chk("to_req_ready", req_ready, 4'b0010);
    step();
    M_ARREADY = 1'b1;
    step();
    M_ARREADY = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("to_rready", M_RREADY, 1);
      chk("to_no_rsp", rsp_valid, 0);
      step();
    end
    req_valid = 4'b1111;
    #1;
    chk("to_rsp_valid", rsp_valid, 4'b0010);
    chk("to_rsp_resp", rsp_resp, 2'b10);
    chk("to_rsp_data", rsp_data, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("drain_rready", M_RREADY, 1);
      chk("drain_busy", busy, 1);
      chk("drain_req_ready", req_ready, 0);
      chk("drain_rsp_valid", rsp_valid, 0);
      step();
    end
    M_RVALID = 1'b1;
    M_RDATA  = 32'h0000_1234;
    #1;
    chk("drain_beat_rready", M_RREADY, 1);
    chk("drain_beat_req_ready", req_ready, 0);
    step();
    M_RVALID = 1'b0;
    #1;
    chk("post_drain_rsp_valid", rsp_valid, 0);
    chk("post_drain_rsp_data", rsp_data, 0);
    chk("post_drain_busy", busy, 0);
    rd(2, 0, 0, 32'h0BAD_F00D, 2'b01);

    // 6: reset in the data phase
    req_valid = 4'b0110;
    #1;
    chk("r6_req_ready", req_ready, 4'b0010);
    step();
    M_ARREADY = 1'b1;
    step();
    M_ARREADY = 1'b0;
    #1;
    chk("r6_rready", M_RREADY, 1);
    #2;
    rst = 1'b1;
    #1;
    check_idle_outputs("r6");
    chk("r6_grant_id", grant_id, 3);
    chk("r6_araddr", M_ARADDR, 0);
    step();
    rst = 1'b0;
    req_valid = 4'b1111;
    rd(0, 0, 0, 32'h0000_7777, 2'b00);
    req_valid = 4'b0000;
    #1;
    check_idle_outputs("end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
